// File: rtl/cordic_scheduler.sv
// Round-robin front end that shares one fixed-latency CORDIC sin/cos core among NUM_REQ clients.
// Issued angles carry an {valid, id, err} tag down a shadow pipeline so results route back to their owner.
module cordic_scheduler #(
  parameter int                 NUM_REQ = 4,
  parameter int                 LATENCY = 16,
  parameter int                 ANGLE_W = 21,
  parameter int                 DATA_W  = 12,
  parameter logic [ANGLE_W-1:0] MAX_MAG = 21'h5A000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0]  req_angle,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_x,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_y,
  output logic [NUM_REQ-1:0]          rsp_err,
  output logic [ANGLE_W-1:0]          cordic_angle,
  input  logic [DATA_W-1:0]           cordic_x,
  input  logic [DATA_W-1:0]           cordic_y,
  output logic                        busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] in_flight;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic               handshake;
  logic [ANGLE_W-1:0] sel_angle;
  logic               sel_err;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_err;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic [NUM_REQ-1:0] retire_oh;
  logic               last_err;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // A requester with an op in flight or an unconsumed result must wait.
  assign eligible = req_valid & ~in_flight & ~rsp_valid;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_any && eligible[wrap_inc(ptr, off)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_inc(ptr, off);
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  assign req_ready = reset ? grant : '0;
  assign handshake = grant_any & reset;

  always_comb begin
    sel_angle = req_angle[int'(grant_id)*ANGLE_W +: ANGLE_W];
    sel_err   = ({1'b0, sel_angle[ANGLE_W-2:0]} > MAX_MAG);
  end

  // Out-of-range angles send 0 to the core; their result is replaced by zeros at retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      cordic_angle <= '0;
    end else if (handshake) begin
      ptr          <= wrap_inc(grant_id, 1);
      cordic_angle <= sel_err ? '0 : sel_angle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_err   <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_valid <= {tag_valid[LATENCY-2:0], handshake};
      tag_err   <= {tag_err[LATENCY-2:0], handshake & sel_err};
      tag_id[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  always_comb begin
    retire_oh = '0;
    if (tag_valid[LATENCY-1]) retire_oh[tag_id[LATENCY-1]] = 1'b1;
  end

  assign last_err = tag_err[LATENCY-1];

  // Retire and consume never target the same slot in one cycle, since a full slot blocks issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
    end else begin
      in_flight <= (in_flight | req_ready) & ~retire_oh;
      rsp_valid <= (rsp_valid & ~rsp_ready) | retire_oh;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (retire_oh[i]) begin
          rsp_err[i]                 <= last_err;
          rsp_x[i*DATA_W +: DATA_W]  <= last_err ? '0 : cordic_x;
          rsp_y[i*DATA_W +: DATA_W]  <= last_err ? '0 : cordic_y;
        end
      end
    end
  end

  assign busy = (|tag_valid) | (|rsp_valid);

endmodule
